// File: rtl/ring_osc_freq_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ring_osc_freq_counter_if
//  Description : Measurement request / result bundle for the ring-oscillator
//                frequency counter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ring_osc_freq_counter_if #(
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16
);
    logic              start;
    logic [GATE_W-1:0] gate_cycles;
    logic              busy;
    logic [CNT_W-1:0]  count;
    logic              count_valid;
    logic              overflow;

    modport master (
        output start,
        output gate_cycles,
        input  busy,
        input  count,
        input  count_valid,
        input  overflow
    );

    modport slave (
        input  start,
        input  gate_cycles,
        output busy,
        output count,
        output count_valid,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/ring_osc_freq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ring_osc_freq_counter
//  Description : Counts rising edges of an asynchronous ring-oscillator tap
//                over a programmable window of system clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_osc_freq_counter #(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              osc_in,
    ring_osc_freq_counter_if.slave meas
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_GATE = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                osc_prev_q;
    logic                osc_s;
    logic                osc_edge;
    logic [GATE_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;

    assign osc_s    = sync_q[SYNC_STAGES-1];
    assign osc_edge = osc_s & ~osc_prev_q;

    // Oscillator resynchronizer and edge detector run every cycle, independent of state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            osc_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], osc_in};
            osc_prev_q <= osc_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            win_q      <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (meas.start && (meas.gate_cycles != '0)) begin
                    win_d   = meas.gate_cycles;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                edge_cnt_d = '0;
                ovf_d      = 1'b0;
                state_d    = S_GATE;
            end
            S_GATE: begin
                if (osc_edge) begin
                    if (&edge_cnt_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                end
                win_d = win_q - GATE_W'(1);
                // Result is published on entry to DONE so it is stable while valid is high.
                if (win_q == GATE_W'(1)) begin
                    count_d    = edge_cnt_d;
                    overflow_d = ovf_d;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    assign meas.busy        = busy_q;
    assign meas.count       = count_q;
    assign meas.count_valid = valid_q;
    assign meas.overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_osc_freq_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ring_osc_freq_counter
//  Description : Self-checking bench for ring_osc_freq_counter (16-bit and
//                4-bit counter instances sharing clock and oscillator).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_osc_freq_counter;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic osc_in = 1'b0;

    always #5 clk = ~clk;

    ring_osc_freq_counter_if #(.CNT_W(16), .GATE_W(16)) mi ();
    ring_osc_freq_counter_if #(.CNT_W(4),  .GATE_W(16)) ni ();

    ring_osc_freq_counter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc_in),
        .meas   (mi)
    );

    ring_osc_freq_counter #(.CNT_W(4)) dut_n (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc_in),
        .meas   (ni)
    );

    // Oscillator model: square wave toggling every osc_half clocks, or a held level.
    int   osc_half  = 0;
    logic osc_level = 1'b0;
    int   osc_ph    = 0;

    always @(negedge clk) begin
        if (osc_half == 0) begin
            osc_in = osc_level;
        end else begin
            osc_ph = osc_ph + 1;
            if (osc_ph >= osc_half) begin
                osc_ph = 0;
                osc_in = ~osc_in;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic set_start(input bit narrow, input logic s, input logic [15:0] g);
        if (narrow) begin
            ni.start       = s;
            ni.gate_cycles = g;
        end else begin
            mi.start       = s;
            mi.gate_cycles = g;
        end
    endtask

    task automatic get_out(input bit narrow, output logic b, output logic v,
                           output logic [15:0] c, output logic o);
        if (narrow) begin
            b = ni.busy; v = ni.count_valid; c = {12'd0, ni.count}; o = ni.overflow;
        end else begin
            b = mi.busy; v = mi.count_valid; c = mi.count; o = mi.overflow;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_osc(input int half, input logic level);
        osc_half  = half;
        osc_level = level;
        repeat (6) tick();
    endtask

    // Cycle 0 is the cycle start is presented; sampling happens just after each later edge.
    task automatic run_meas(input bit narrow, input int gate, input int extra_at,
                            output logic [15:0] cnt, output logic ovf,
                            output int vcyc, output int nvalid, output int nbusy);
        logic b, v, o;
        logic [15:0] c;
        logic [15:0] g16;
        g16 = gate[15:0];
        set_start(narrow, 1'b1, g16);
        tick();
        set_start(narrow, 1'b0, 16'($urandom));
        vcyc = -1; nvalid = 0; nbusy = 0; cnt = '0; ovf = 1'b0;
        for (int cy = 1; cy <= gate + 6; cy++) begin
            if (cy == extra_at)          set_start(narrow, 1'b1, g16);
            else if (cy == extra_at + 1) set_start(narrow, 1'b0, 16'($urandom));
            get_out(narrow, b, v, c, o);
            if (b) nbusy++;
            if (v) begin
                nvalid++;
                vcyc = cy;
                cnt  = c;
                ovf  = o;
            end
            tick();
        end
        set_start(narrow, 1'b0, '0);
    endtask

    task automatic run_and_check(input string tag, input bit narrow, input int gate,
                                 input int lo, input int hi, input bit exp_ovf,
                                 input int extra_at);
        logic [15:0] cnt;
        logic        ovf;
        int          vcyc, nvalid, nbusy;
        run_meas(narrow, gate, extra_at, cnt, ovf, vcyc, nvalid, nbusy);
        check(        {tag, "_valid_pulses"}, nvalid, 1);
        check(        {tag, "_valid_cycle"},  vcyc,   gate + 2);
        check(        {tag, "_busy_cycles"},  nbusy,  gate + 2);
        check_rng(    {tag, "_count"},        cnt,    lo, hi);
        check(        {tag, "_overflow"},     ovf,    exp_ovf);
    endtask

    typedef struct {
        int   half;
        logic level;
        bit   narrow;
        int   gate;
        int   lo;
        int   hi;
        bit   ovf;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic b, v, o;
        logic [15:0] c;
        int   bseen, vseen;

        tbl[0] = '{4, 1'b0, 1'b0, 80,  10, 10, 1'b0};
        tbl[1] = '{0, 1'b0, 1'b0, 50,  0,  0,  1'b0};
        tbl[2] = '{0, 1'b1, 1'b0, 50,  0,  0,  1'b0};
        tbl[3] = '{2, 1'b0, 1'b1, 100, 15, 15, 1'b1};
        tbl[4] = '{4, 1'b0, 1'b1, 40,  5,  5,  1'b0};
        tbl[5] = '{1, 1'b0, 1'b0, 1,   0,  1,  1'b0};
        tbl[6] = '{1, 1'b0, 1'b0, 64,  32, 32, 1'b0};
        tbl[7] = '{8, 1'b0, 1'b0, 160, 10, 10, 1'b0};
        tbl[8] = '{1, 1'b0, 1'b1, 30,  15, 15, 1'b0};
        tbl[9] = '{1, 1'b0, 1'b1, 32,  15, 15, 1'b1};

        set_start(1'b0, 1'b0, '0);
        set_start(1'b1, 1'b0, '0);
        rst_n = 1'b0;
        repeat (3) tick();

        check("reset_busy",     mi.busy,        0);
        check("reset_count",    mi.count,       0);
        check("reset_valid",    mi.count_valid, 0);
        check("reset_overflow", mi.overflow,    0);
        check("reset_n_busy",   ni.busy,        0);
        check("reset_n_count",  ni.count,       0);

        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 10; i++) begin
            set_osc(tbl[i].half, tbl[i].level);
            run_and_check($sformatf("vec%0d", i), tbl[i].narrow, tbl[i].gate,
                          tbl[i].lo, tbl[i].hi, tbl[i].ovf, -1);
        end

        // Randomized windows; expected edge count comes from period arithmetic.
        for (int i = 0; i < 12; i++) begin
            int  half, per, k, gate, lo, hi;
            bit  narrow, eovf;
            half   = $urandom_range(1, 6);
            per    = 2 * half;
            k      = $urandom_range(1, 20);
            gate   = k * per;
            narrow = 1'b0;
            eovf   = 1'b0;
            if (i % 3 == 2) begin
                gate = gate + $urandom_range(1, per - 1);
                lo   = gate / per;
                hi   = (gate + per - 1) / per;
            end else begin
                narrow = (i % 2 == 1);
                lo     = k;
                if (narrow && k > 15) begin
                    lo   = 15;
                    eovf = 1'b1;
                end
                hi = lo;
            end
            set_osc(half, 1'b0);
            run_and_check($sformatf("rnd%0d", i), narrow, gate, lo, hi, eovf, -1);
        end

        // Start re-requested mid-window must not launch a second measurement.
        set_osc(4, 1'b0);
        run_and_check("start_in_gate", 1'b0, 40, 5, 5, 1'b0, 20);

        // Zero-length window request is ignored entirely.
        set_start(1'b0, 1'b1, 16'd0);
        tick();
        set_start(1'b0, 1'b0, 16'd0);
        bseen = 0; vseen = 0;
        for (int cy = 0; cy < 8; cy++) begin
            get_out(1'b0, b, v, c, o);
            if (b) bseen++;
            if (v) vseen++;
            tick();
        end
        check("zero_gate_busy",  bseen,    0);
        check("zero_gate_valid", vseen,    0);
        check("zero_gate_count", mi.count, 5);

        // Asynchronous reset in the middle of a window.
        set_start(1'b0, 1'b1, 16'd100);
        tick();
        set_start(1'b0, 1'b0, 16'd0);
        repeat (20) tick();
        check("mid_gate_busy", mi.busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy",     mi.busy,        0);
        check("rst_mid_count",    mi.count,       0);
        check("rst_mid_valid",    mi.count_valid, 0);
        check("rst_mid_overflow", mi.overflow,    0);
        tick();
        tick();
        rst_n = 1'b1;
        vseen = 0; bseen = 0;
        for (int cy = 0; cy < 120; cy++) begin
            get_out(1'b0, b, v, c, o);
            if (b) bseen++;
            if (v) vseen++;
            tick();
        end
        check("post_rst_valid", vseen, 0);
        check("post_rst_busy",  bseen, 0);
        set_osc(4, 1'b0);
        run_and_check("post_rst_run", 1'b0, 16, 2, 2, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
